game_timer: RTL
===============

Name: game_timer

Overview:
- Quarter game clock for the basketball scoreboard; sits directly downstream of the clock divider.
- Consumes the divider's 1 s square-wave output as a tick source and counts a quarter down from PERIOD_MIN:00 to 00:00.
- Drives BCD digits for the display multiplexer, plus quarter number, buzzer and end-of-game flags.
- Everything runs on the single 50 MHz clock; the tick is used as an enable, never as a clock.

Parameters:
- PERIOD_MIN, 10, quarter length in minutes (1..99), loaded as PERIOD_MIN:00.
- NUM_QUARTERS, 4, quarters per game (1..7).
- BUZZ_TICKS, 2, number of tick edges the buzzer stays high after expiry (>=1).

Ports:
- clock_in  in  1  system clock, 50 MHz
- reset_n  in  1  synchronous, active-low reset
- tick_in  in  1  1 s square wave from the divider; each rising edge = one second
- btn_start  in  1  asynchronous push button; each rising edge toggles run/pause
- btn_next  in  1  asynchronous push button; each rising edge advances the quarter after expiry
- min_tens  out  4  BCD
- min_ones  out  4  BCD
- sec_tens  out  4  BCD (0..5)
- sec_ones  out  4  BCD
- quarter  out  3  current quarter, 1..NUM_QUARTERS
- running  out  1  high in RUNNING
- buzzer  out  1  expiry horn
- game_over  out  1  high in FINAL

Behaviour:
- Interface: one clock; reset is synchronous and active-low. Clock port is clock_in; reset port is reset_n.
- All outputs are registered.
- Reset values (on any clock edge with reset_n=0, including mid-count):
  - state IDLE; digits = PERIOD_MIN:00 (tens = PERIOD_MIN/10, ones = PERIOD_MIN%10); quarter=1.
  - running=0, buzzer=0, game_over=0; buzzer counter cleared; all edge/sync registers cleared.
- Tick edge: tick_rise = tick_in & ~tick_q, where tick_q is tick_in delayed by one flop. tick_in is already in the clock_in domain, so it gets no synchronizer.
- Buttons: 2-flop synchronizer, then rising-edge detect. Action takes effect on the 3rd clock_in edge after the button rises. A held button produces exactly one event.
- States: IDLE, RUNNING, PAUSED, EXPIRED, FINAL.
  - IDLE: start -> RUNNING.
  - RUNNING: start -> PAUSED. tick_rise -> decrement. If the decrement produces 00:00 -> EXPIRED.
  - PAUSED: start -> RUNNING. Ticks are ignored.
  - EXPIRED: next with quarter<NUM_QUARTERS -> IDLE, quarter+1, digits reloaded. Next with quarter==NUM_QUARTERS -> FINAL. Start is ignored.
  - FINAL: game_over=1; all inputs ignored; only reset exits.
  - next is ignored in every state except EXPIRED.
- Decrement (one tick, all digits updated on the same edge):
  - sec_ones>0 -> sec_ones-1.
  - Otherwise sec_ones=9, and:
    - sec_tens>0 -> sec_tens-1;
    - otherwise sec_tens=5 and minutes borrow BCD-wise (min_ones 0 -> 9 with min_tens-1).
  - 00:00 is never decremented; no wrap below zero.
- Simultaneous tick_rise and start in RUNNING: the decrement is applied AND the state goes to PAUSED on the same edge.
  - If that decrement reaches 00:00, EXPIRED takes priority over PAUSED.
- Partial first second: the first decrement occurs at the first tick_rise after entering RUNNING. No phase alignment to the tick.
- running output follows the state on the same edge as the transition.
- Buzzer:
  - Set on the edge that enters EXPIRED.
  - Stays high for BUZZ_TICKS subsequent tick_rise events, counted in EXPIRED and FINAL, then clears.
  - If next is pressed while the buzzer is active, the buzzer clears on the transition edge.

Decomposition:
- Shared package scoreboard_pkg:
  - timer state enum (3-bit encoding);
  - BCD digit width constant (4);
  - default period/quarter constants shared with the score and shot-clock blocks.
- One sub-module, rise_detect: 2-flop synchronizer plus edge register, with a bypass parameter for already-synchronous inputs.
  - Instantiated three times: tick_in (bypass) and both buttons.
- BCD decrement logic stays inline.

Test Plan:
1. PERIOD_MIN=1, reset, start, 60 tick edges -> digits go 01:00, 00:59 … 00:01, 00:00; state EXPIRED; buzzer=1 on the expiry edge; running=0.
2. Borrow case: PERIOD_MIN=10, start, 1 tick -> 09:59 (min_tens=0, min_ones=9, sec_tens=5, sec_ones=9); after 50 more ticks -> 09:09.
3. Pause: start, 5 ticks (09:55), start, 10 ticks, start, 1 tick -> 09:54; running toggles 1/0/1.
4. Same-cycle tick and start edge at 09:30 -> 09:29 and PAUSED on that edge; a further tick leaves 09:29.
5. Quarter flow, NUM_QUARTERS=2, PERIOD_MIN=1: expire, next -> quarter=2, 01:00, IDLE; expire, next -> game_over=1; further start/next have no effect; buzzer clears after BUZZ_TICKS=2 ticks.
6. reset_n low for one cycle while RUNNING at 00:17 in quarter 3 -> next cycle: 10:00, quarter=1, IDLE, buzzer=0, game_over=0; btn_start held high for 100 cycles yields exactly one start.

Source files
------------

// File: rtl/scoreboard_pkg.sv
// Shared definitions for the scoreboard blocks: timer states, BCD width
// and default game geometry used by the timer, score and shot-clock blocks.
package scoreboard_pkg;

    typedef enum logic [2:0] {
        TS_IDLE    = 3'd0,
        TS_RUNNING = 3'd1,
        TS_PAUSED  = 3'd2,
        TS_EXPIRED = 3'd3,
        TS_FINAL   = 3'd4
    } timer_state_t;

    localparam int BCD_W                = 4;
    localparam int DEFAULT_PERIOD_MIN   = 10;
    localparam int DEFAULT_NUM_QUARTERS = 4;
    localparam int DEFAULT_BUZZ_TICKS   = 2;

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector with an optional 2-flop synchronizer; BYPASS=1 is
// for inputs already in the local clock domain (single delay flop only).
module rise_detect #(
    parameter bit BYPASS = 1'b0
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_sig,
    output logic o_rise
);

    generate
        if (BYPASS) begin : g_bypass
            logic r_q;

            always_ff @(posedge i_clk) begin
                if (!i_reset_n) r_q <= 1'b0;
                else            r_q <= i_sig;
            end

            assign o_rise = i_sig & ~r_q;
        end else begin : g_sync
            logic r_s1;
            logic r_s2;
            logic r_q;

            always_ff @(posedge i_clk) begin
                if (!i_reset_n) begin
                    r_s1 <= 1'b0;
                    r_s2 <= 1'b0;
                    r_q  <= 1'b0;
                end else begin
                    r_s1 <= i_sig;
                    r_s2 <= r_s1;
                    r_q  <= r_s2;
                end
            end

            assign o_rise = r_s2 & ~r_q;
        end
    endgenerate

endmodule

// File: rtl/game_timer.sv
// Quarter game clock: counts PERIOD_MIN:00 down to 00:00 in BCD on each
// divider tick, tracks quarters, and drives buzzer / game-over flags.
module game_timer
    import scoreboard_pkg::*;
#(
    parameter int PERIOD_MIN   = DEFAULT_PERIOD_MIN,
    parameter int NUM_QUARTERS = DEFAULT_NUM_QUARTERS,
    parameter int BUZZ_TICKS   = DEFAULT_BUZZ_TICKS
) (
    input  logic             clock_in,
    input  logic             reset_n,
    input  logic             tick_in,
    input  logic             btn_start,
    input  logic             btn_next,
    output logic [BCD_W-1:0] min_tens,
    output logic [BCD_W-1:0] min_ones,
    output logic [BCD_W-1:0] sec_tens,
    output logic [BCD_W-1:0] sec_ones,
    output logic [2:0]       quarter,
    output logic             running,
    output logic             buzzer,
    output logic             game_over
);

    localparam int               CW      = $clog2(BUZZ_TICKS + 1);
    localparam logic [BCD_W-1:0] LOAD_MT = BCD_W'(PERIOD_MIN / 10);
    localparam logic [BCD_W-1:0] LOAD_MO = BCD_W'(PERIOD_MIN % 10);
    localparam logic [2:0]       LAST_Q  = 3'(NUM_QUARTERS);
    localparam logic [CW-1:0]    BUZZ_N  = CW'(BUZZ_TICKS);

    timer_state_t     r_state;
    logic [BCD_W-1:0] r_minTens, r_minOnes, r_secTens, r_secOnes;
    logic [2:0]       r_quarter;
    logic             r_running, r_buzzer, r_gameOver;
    logic [CW-1:0]    r_buzzCnt;

    timer_state_t     w_nextState;
    logic [BCD_W-1:0] w_minTens, w_minOnes, w_secTens, w_secOnes;
    logic [BCD_W-1:0] w_decMt, w_decMo, w_decSt, w_decSo;
    logic [2:0]       w_quarter;
    logic             w_buzzer;
    logic [CW-1:0]    w_buzzCnt;
    logic             w_tickRise, w_startRise, w_nextRise;
    logic             w_isZero, w_decZero;

    rise_detect #(.BYPASS(1'b1)) u_tick (
        .i_clk(clock_in), .i_reset_n(reset_n), .i_sig(tick_in), .o_rise(w_tickRise)
    );

    rise_detect #(.BYPASS(1'b0)) u_start (
        .i_clk(clock_in), .i_reset_n(reset_n), .i_sig(btn_start), .o_rise(w_startRise)
    );

    rise_detect #(.BYPASS(1'b0)) u_next (
        .i_clk(clock_in), .i_reset_n(reset_n), .i_sig(btn_next), .o_rise(w_nextRise)
    );

    assign w_isZero  = ({r_minTens, r_minOnes, r_secTens, r_secOnes} == '0);
    assign w_decZero = ({w_decMt, w_decMo, w_decSt, w_decSo} == '0);

    // One-second BCD decrement with borrow rippling through all four digits.
    always_comb begin
        w_decMt = r_minTens;
        w_decMo = r_minOnes;
        w_decSt = r_secTens;
        w_decSo = r_secOnes;
        if (r_secOnes != 4'd0) begin
            w_decSo = r_secOnes - 4'd1;
        end else begin
            w_decSo = 4'd9;
            if (r_secTens != 4'd0) begin
                w_decSt = r_secTens - 4'd1;
            end else begin
                w_decSt = 4'd5;
                if (r_minOnes != 4'd0) begin
                    w_decMo = r_minOnes - 4'd1;
                end else begin
                    w_decMo = 4'd9;
                    w_decMt = r_minTens - 4'd1;
                end
            end
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_minTens   = r_minTens;
        w_minOnes   = r_minOnes;
        w_secTens   = r_secTens;
        w_secOnes   = r_secOnes;
        w_quarter   = r_quarter;
        w_buzzer    = r_buzzer;
        w_buzzCnt   = r_buzzCnt;

        case (r_state)
            TS_IDLE: begin
                if (w_startRise) w_nextState = TS_RUNNING;
            end
            TS_RUNNING: begin
                // Expiry on the decrementing tick outranks a simultaneous pause.
                if (w_tickRise && !w_isZero) begin
                    w_minTens = w_decMt;
                    w_minOnes = w_decMo;
                    w_secTens = w_decSt;
                    w_secOnes = w_decSo;
                end
                if (w_tickRise && !w_isZero && w_decZero) begin
                    w_nextState = TS_EXPIRED;
                    w_buzzer    = 1'b1;
                    w_buzzCnt   = '0;
                end else if (w_startRise) begin
                    w_nextState = TS_PAUSED;
                end
            end
            TS_PAUSED: begin
                if (w_startRise) w_nextState = TS_RUNNING;
            end
            TS_EXPIRED: begin
                if (w_nextRise) begin
                    w_buzzer  = 1'b0;
                    w_buzzCnt = '0;
                    if (r_quarter < LAST_Q) begin
                        w_nextState = TS_IDLE;
                        w_quarter   = r_quarter + 3'd1;
                        w_minTens   = LOAD_MT;
                        w_minOnes   = LOAD_MO;
                        w_secTens   = 4'd0;
                        w_secOnes   = 4'd0;
                    end else begin
                        w_nextState = TS_FINAL;
                    end
                end else if (w_tickRise && r_buzzer) begin
                    if (r_buzzCnt + CW'(1) == BUZZ_N) begin
                        w_buzzer  = 1'b0;
                        w_buzzCnt = '0;
                    end else begin
                        w_buzzCnt = r_buzzCnt + CW'(1);
                    end
                end
            end
            TS_FINAL: begin
                if (w_tickRise && r_buzzer) begin
                    if (r_buzzCnt + CW'(1) == BUZZ_N) begin
                        w_buzzer  = 1'b0;
                        w_buzzCnt = '0;
                    end else begin
                        w_buzzCnt = r_buzzCnt + CW'(1);
                    end
                end
            end
            default: w_nextState = TS_IDLE;
        endcase
    end

    always_ff @(posedge clock_in) begin
        if (!reset_n) begin
            r_state    <= TS_IDLE;
            r_minTens  <= LOAD_MT;
            r_minOnes  <= LOAD_MO;
            r_secTens  <= 4'd0;
            r_secOnes  <= 4'd0;
            r_quarter  <= 3'd1;
            r_running  <= 1'b0;
            r_buzzer   <= 1'b0;
            r_gameOver <= 1'b0;
            r_buzzCnt  <= '0;
        end else begin
            r_state    <= w_nextState;
            r_minTens  <= w_minTens;
            r_minOnes  <= w_minOnes;
            r_secTens  <= w_secTens;
            r_secOnes  <= w_secOnes;
            r_quarter  <= w_quarter;
            r_running  <= (w_nextState == TS_RUNNING);
            r_buzzer   <= w_buzzer;
            r_gameOver <= (w_nextState == TS_FINAL);
            r_buzzCnt  <= w_buzzCnt;
        end
    end

    assign min_tens  = r_minTens;
    assign min_ones  = r_minOnes;
    assign sec_tens  = r_secTens;
    assign sec_ones  = r_secOnes;
    assign quarter   = r_quarter;
    assign running   = r_running;
    assign buzzer    = r_buzzer;
    assign game_over = r_gameOver;

endmodule
